// File: rtl/fa_exhaustive_checker.sv
// Exhaustive self-test sequencer for a 1-bit full adder: walks all eight input
// vectors, lets each one settle, then compares the adder response to a reference.
module fa_exhaustive_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       a,
  output logic       b,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail
);

  // A zero settle time still needs one cycle for the stimulus to reach the DUT.
  localparam int          SETTLE_EFF  = (SETTLE < 1) ? 1 : SETTLE;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t      state;
  logic [31:0] settle_cnt;
  logic [2:0]  idx;
  logic        exp_sum;
  logic        exp_cout;
  logic        mismatch;

  // Stimulus is the vector index itself, a as MSB.
  assign {a, b, cin} = idx;

  always_comb begin
    exp_sum  = idx[2] ^ idx[1] ^ idx[0];
    exp_cout = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
    mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            settle_cnt <= '0;
            idx        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
            first_fail <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 32'd1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count      <= err_count + 4'd1;
            fail_mask[idx] <= 1'b1;
            if (err_count == 4'd0) first_fail <= idx;
          end
          if (idx == 3'd7) begin
            // Stimulus deliberately stays at 111 while results are held.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == 4'd0);
          end else begin
            idx   <= idx + 3'd1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
